// File: rtl/twobit_compare_tally_if.sv
// twobit_compare_tally_if
// Groups the comparator sample strobe/codes and the tally results shared
// between the comparator side (master) and the tally block (slave).
interface twobit_compare_tally_if #(
  parameter int CNT_W = 8
);
  logic             InValid;
  logic             InF1;
  logic             InF2;
  logic             InF3;
  logic             InClear;
  logic [CNT_W-1:0] OutGtCnt;
  logic [CNT_W-1:0] OutEqCnt;
  logic [CNT_W-1:0] OutLtCnt;
  logic             OutEqRun;
  logic             OutErr;
  logic [1:0]       OutState;

  modport master (
    output InValid, InF1, InF2, InF3, InClear,
    input  OutGtCnt, OutEqCnt, OutLtCnt, OutEqRun, OutErr, OutState
  );

  modport slave (
    input  InValid, InF1, InF2, InF3, InClear,
    output OutGtCnt, OutEqCnt, OutLtCnt, OutEqRun, OutErr, OutState
  );
endinterface

// File: rtl/twobit_compare_tally.sv
// twobit_compare_tally
// Accumulates one-hot results of the 2-bit magnitude comparator, tracks a
// streak of equal results and latches an error on malformed codes.
// Optional build macro: TALLY_SAT_EN -- counters saturate instead of wrapping.
module twobit_compare_tally #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input logic                  InClk,
  input logic                  InRstN,
  twobit_compare_tally_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_ALARM = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  localparam logic [3:0] RUN_LEN_L = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [3:0]       streak_q, streak_d;
  logic             err_q, err_d;
  logic             eq_run_q, eq_run_d;
  logic [1:0]       state_q, state_d;

  logic [2:0] code;
  logic       one_hot;

  // Next value of an outcome counter: saturating or wrapping by build option
  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] cnt);
`ifdef TALLY_SAT_EN
    inc_cnt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
`else
    inc_cnt = cnt + CNT_ONE;
`endif
  endfunction

  // Classify the incoming comparator code as a legal one-hot result or not
  always_comb begin
    code    = {bus.InF1, bus.InF2, bus.InF3};
    one_hot = (code == 3'b100) || (code == 3'b010) || (code == 3'b001);
  end

  // Next-state logic: clear beats a sample; ERROR freezes everything
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    streak_d = streak_q;
    err_d    = err_q;
    state_d  = state_q;
    if (bus.InClear) begin
      gt_cnt_d = '0;
      eq_cnt_d = '0;
      lt_cnt_d = '0;
      streak_d = '0;
      err_d    = 1'b0;
      state_d  = ST_IDLE;
    end else if (bus.InValid && (state_q != ST_ERROR)) begin
      if (one_hot) begin
        if (bus.InF1) gt_cnt_d = inc_cnt(gt_cnt_q);
        if (bus.InF2) eq_cnt_d = inc_cnt(eq_cnt_q);
        if (bus.InF3) lt_cnt_d = inc_cnt(lt_cnt_q);
        if (bus.InF2) begin
          streak_d = (streak_q >= RUN_LEN_L) ? RUN_LEN_L : streak_q + 4'd1;
        end else begin
          streak_d = '0;
        end
        case (state_q)
          ST_IDLE:  state_d = ST_TRACK;
          ST_TRACK: if (streak_d == RUN_LEN_L) state_d = ST_ALARM;
          ST_ALARM: if (!bus.InF2) state_d = ST_TRACK;
          default:  state_d = state_q;
        endcase
      end else begin
        err_d   = 1'b1;
        state_d = ST_ERROR;
      end
    end
    eq_run_d = (state_d == ST_ALARM);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge InClk) begin
    if (!InRstN) begin
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
      eq_run_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      eq_run_q <= eq_run_d;
      state_q  <= state_d;
    end
  end

  // Drive registered results onto the interface
  always_comb begin
    bus.OutGtCnt = gt_cnt_q;
    bus.OutEqCnt = eq_cnt_q;
    bus.OutLtCnt = lt_cnt_q;
    bus.OutEqRun = eq_run_q;
    bus.OutErr   = err_q;
    bus.OutState = state_q;
  end

endmodule

// File: tb/tb_twobit_compare_tally.sv
// tb_twobit_compare_tally
// Directed bench for twobit_compare_tally. Observed word layout:
// {Gt[7:0], Eq[7:0], Lt[7:0], EqRun, Err, State[1:0]}.
// Honors TALLY_SAT_EN for the overflow expectation.
module tb_twobit_compare_tally;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  twobit_compare_tally_if #(.CNT_W(8)) bus ();

  twobit_compare_tally #(.CNT_W(8), .RUN_LEN(3)) dut (
    .InClk  (clk),
    .InRstN (rst_n),
    .bus    (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot of every output, packed for compact comparison
  function automatic logic [27:0] snap();
    snap = {bus.OutGtCnt, bus.OutEqCnt, bus.OutLtCnt, bus.OutEqRun, bus.OutErr, bus.OutState};
  endfunction

  // Advance one clock and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sample for one edge
  task automatic send(input logic [2:0] code);
    bus.InValid = 1'b1;
    {bus.InF1, bus.InF2, bus.InF3} = code;
    tick();
    bus.InValid = 1'b0;
    {bus.InF1, bus.InF2, bus.InF3} = 3'b000;
  endtask

  // Pulse InClear for one edge
  task automatic do_clear();
    bus.InClear = 1'b1;
    tick();
    bus.InClear = 1'b0;
  endtask

  // Reset held two cycles, then idle
  task automatic test_reset();
    logic [27:0] exp;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp = {8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL reset_state got=%h want=%h", snap(), exp);
    end
  endtask

  // Mixed stream of legal codes
  task automatic test_mixed();
    logic [27:0] exp;
    do_clear();
    send(3'b100);
    exp = {8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL mixed_first got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    send(3'b001);
    send(3'b100);
    exp = {8'd2, 8'd1, 8'd1, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL mixed_stream got=%h want=%h", snap(), exp);
    end
  endtask

  // Equal streak with an idle gap, then broken by A>B
  task automatic test_streak();
    logic [27:0] exp;
    do_clear();
    send(3'b010);
    send(3'b010);
    tick();
    exp = {8'd0, 8'd2, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL streak_two got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    exp = {8'd0, 8'd3, 8'd0, 1'b1, 1'b0, 2'b10};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL streak_alarm got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    exp = {8'd0, 8'd4, 8'd0, 1'b1, 1'b0, 2'b10};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL streak_hold got=%h want=%h", snap(), exp);
    end
    send(3'b100);
    exp = {8'd1, 8'd4, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL streak_break got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    exp = {8'd1, 8'd5, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL streak_restart got=%h want=%h", snap(), exp);
    end
  endtask

  // Non-one-hot codes latch error and freeze the tally
  task automatic test_error();
    logic [27:0] exp;
    do_clear();
    send(3'b100);
    send(3'b110);
    exp = {8'd1, 8'd0, 8'd0, 1'b0, 1'b1, 2'b11};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL error_enter got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    send(3'b010);
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL error_frozen got=%h want=%h", snap(), exp);
    end
    do_clear();
    exp = {8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL error_clear got=%h want=%h", snap(), exp);
    end
    send(3'b000);
    exp = {8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 2'b11};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL error_zero_code got=%h want=%h", snap(), exp);
    end
    do_clear();
  endtask

  // Clear and valid on the same edge: sample dropped
  task automatic test_clear_collision();
    logic [27:0] exp;
    do_clear();
    send(3'b100);
    bus.InClear = 1'b1;
    bus.InValid = 1'b1;
    {bus.InF1, bus.InF2, bus.InF3} = 3'b001;
    tick();
    bus.InClear = 1'b0;
    bus.InValid = 1'b0;
    {bus.InF1, bus.InF2, bus.InF3} = 3'b000;
    exp = {8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b00};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL clear_collision got=%h want=%h", snap(), exp);
    end
  endtask

  // Reset mid-streak discards the streak
  task automatic test_reset_mid_streak();
    logic [27:0] exp;
    do_clear();
    send(3'b010);
    send(3'b010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(3'b010);
    send(3'b010);
    exp = {8'd0, 8'd2, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL reset_streak_two got=%h want=%h", snap(), exp);
    end
    send(3'b010);
    exp = {8'd0, 8'd3, 8'd0, 1'b1, 1'b0, 2'b10};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL reset_streak_alarm got=%h want=%h", snap(), exp);
    end
  endtask

  // Full-rate samples every cycle
  task automatic test_back_to_back();
    logic [27:0] exp;
    logic [2:0]  seq [8];
    seq = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b001, 3'b100, 3'b100, 3'b010};
    do_clear();
    for (int i = 0; i < 8; i++) send(seq[i]);
    exp = {8'd3, 8'd3, 8'd2, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL back_to_back got=%h want=%h", snap(), exp);
    end
  endtask

  // Counter boundary at 2^CNT_W-1
  task automatic test_overflow();
    logic [27:0] exp;
    do_clear();
    for (int i = 0; i < 255; i++) send(3'b100);
    exp = {8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 2'b01};
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL overflow_max got=%h want=%h", snap(), exp);
    end
    send(3'b100);
`ifdef TALLY_SAT_EN
    exp = {8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 2'b01};
`else
    exp = {8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'b01};
`endif
    compared++;
    if (snap() !== exp) begin
      mismatched++;
      $display("[TB] FAIL overflow_wrap got=%h want=%h", snap(), exp);
    end
  endtask

  // Run every scenario in order, then summarize
  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    bus.InValid = 1'b0;
    bus.InClear = 1'b0;
    bus.InF1    = 1'b0;
    bus.InF2    = 1'b0;
    bus.InF3    = 1'b0;
    test_reset();
    test_mixed();
    test_streak();
    test_error();
    test_clear_collision();
    test_reset_mid_streak();
    test_back_to_back();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/twobit_compare_tally.md
# twobit_compare_tally

Downstream result accumulator for the 2-bit magnitude comparator. It samples the comparator's three one-hot outputs (A>B, A=B, A<B) under a valid strobe and keeps a running count of each outcome. It flags a run of consecutive equal results and latches an error on any non-one-hot code. Its outputs feed the board LED/7-segment display stage.

## Interface

Parameters:
- CNT_W, 8, width of each outcome counter
- RUN_LEN, 3, consecutive equal samples that raise OutEqRun (1..15)

Ports:
- InClk  input  1  clock; all logic updates on its rising edge
- InRstN  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- InValid  input  1  sample strobe; InF1..InF3 are sampled on the edge where it is 1
- InF1  input  1  comparator A>B
- InF2  input  1  comparator A=B
- InF3  input  1  comparator A<B
- InClear  input  1  synchronous clear of counters, run tracker, error and FSM
- OutGtCnt  output  CNT_W  number of accepted A>B samples
- OutEqCnt  output  CNT_W  number of accepted A=B samples
- OutLtCnt  output  CNT_W  number of accepted A<B samples
- OutEqRun  output  1  high while the equal streak is >= RUN_LEN
- OutErr  output  1  sticky: a non-one-hot sample was seen
- OutState  output  2  FSM state: 00 IDLE, 01 TRACK, 10 ALARM, 11 ERROR

## Operation

- Precedence on each edge: InRstN=0, then InClear=1, then InValid=1, then hold.
- A sample is accepted when InValid=1, the FSM is not in ERROR, and {InF1,InF2,InF3} is exactly one-hot.
- Accepted sample effects:
  - F1 increments OutGtCnt, F2 increments OutEqCnt, F3 increments OutLtCnt.
  - Streak counter (4 bits) increments on F2 and saturates at RUN_LEN. It goes to 0 on F1 or F3.
  - Cycles with InValid=0 leave the streak unchanged.
- A valid non-one-hot sample (000, 011, 101, 110, 111) is not counted. It sets OutErr and moves the FSM to ERROR.
- FSM:
  - IDLE -> TRACK on the first accepted sample.
  - TRACK -> ALARM when the post-update streak equals RUN_LEN.
  - ALARM -> TRACK when an accepted F1/F3 sample clears the streak.
  - IDLE, TRACK or ALARM -> ERROR on a non-one-hot valid sample.
  - ERROR is held until InClear or reset. While in ERROR, InValid is ignored and counters are frozen.
  - Any state -> IDLE on InClear or reset.
- OutEqRun = (OutState == ALARM).
- Counters hold or wrap at 2^CNT_W-1 per Configuration.

## Timing

- All outputs are registered. A sample accepted on edge N is visible after edge N, i.e. 1-cycle latency. No combinational input-to-output path.
- Reset value of every output: all counters 0, OutEqRun 0, OutErr 0, OutState 00. Streak is also 0.
- InClear gives the same values as reset on the following edge and has priority over a simultaneous InValid: that sample is dropped.
- Reset or clear mid-streak discards the streak. ALARM is re-entered only after RUN_LEN new equal samples.
- Back-to-back InValid every cycle is supported at full rate.

## Configuration

- TALLY_SAT_EN defined: each counter saturates at 2^CNT_W-1; further samples of that kind leave it unchanged.
- TALLY_SAT_EN undefined: counters wrap modulo 2^CNT_W (255+1 -> 0 at CNT_W=8).
- Streak, FSM and error logic are identical in both builds.

## Test plan

- Reset then idle: hold InRstN=0 for 2 cycles, release with InValid=0 -> all counters 0, OutErr 0, OutState 00.
- Mixed stream: valid codes 100, 010, 001, 100 on consecutive cycles -> Gt=2, Eq=1, Lt=1, OutState=01, OutEqRun=0.
- Equal streak with gap (RUN_LEN=3): 010, 010, idle cycle, 010 -> OutEqRun=1 and OutState=10 after the third valid edge. A following 100 -> OutEqRun=0, OutState=01, Gt=1.
- Error: valid code 110 -> OutErr=1, OutState=11, counters unchanged. Further valid 010 samples are ignored. InClear -> all outputs 0, OutState=00.
- Clear vs valid collision: InClear=1 and InValid=1 with 001 on the same edge -> Lt=0, OutState=00.
- Overflow (CNT_W=8): 256 valid 100 samples -> Gt=255 with TALLY_SAT_EN, Gt=0 without it.
